// File: rtl/mem_addr_pkg.sv
// Shared definitions for the registered memory-address selector:
// FSM state encoding, access-size codes and the default exception vector.
package mem_addr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_00FF;

  // The reserved size code 11 falls through to the word rule.
  function automatic logic is_aligned(input logic [1:0] lsb, input logic [1:0] size);
    case (size)
      SZ_HALF: is_aligned = !lsb[0];
      SZ_BYTE: is_aligned = 1'b1;
      default: is_aligned = (lsb == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/addr_src_mux.sv
// Combinational N-way address source select. An out-of-range select
// falls back to source 0 and raises sel_err.
module addr_src_mux #(
  parameter int WIDTH = 32,
  parameter int N_SRC = 4,
  parameter int SEL_W = $clog2(N_SRC)
) (
  input  logic [SEL_W-1:0]       sel,
  input  logic [N_SRC*WIDTH-1:0] addr_src,
  output logic [WIDTH-1:0]       src,
  output logic                   sel_err
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    src     = addr_src[0 +: WIDTH];
    sel_err = 1'b1;
    for (int i = 0; i < N_SRC; i++) begin
      if (sel == SEL_W'(i)) begin
        src     = addr_src[i*WIDTH +: WIDTH];
        sel_err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_addr_sel_seq.sv
// Registered memory-address selector: picks a source, checks alignment,
// counts memory wait states and hands busy/done/fault pulses to control.
module mem_addr_sel_seq
  import mem_addr_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               N_SRC       = 4,
  parameter int               SEL_W       = $clog2(N_SRC),
  parameter int               WAIT_CYCLES = 1,
  parameter logic [WIDTH-1:0] EXC_VECTOR  = WIDTH'(EXC_VECTOR_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SEL_W-1:0]       addr_sel,
  input  logic [N_SRC*WIDTH-1:0] addr_src,
  input  logic                   req,
  input  logic [1:0]             acc_size,
  input  logic                   exc_force,
  output logic [WIDTH-1:0]       mem_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   misaligned,
  output logic                   sel_err
);

  localparam int             CNT_W    = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] src;
  logic             src_err;
  logic             aligned;

  addr_src_mux #(
    .WIDTH (WIDTH),
    .N_SRC (N_SRC),
    .SEL_W (SEL_W)
  ) u_mux (
    .sel      (addr_sel),
    .addr_src (addr_src),
    .src      (src),
    .sel_err  (src_err)
  );

  assign aligned = is_aligned(src[1:0], acc_size);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      mem_addr   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      sel_err    <= 1'b0;
    end else begin
      // NOTE: pulse outputs drop every edge; only the branch that fires one raises it.
      done       <= 1'b0;
      misaligned <= 1'b0;
      sel_err    <= 1'b0;
      if (exc_force) begin
        mem_addr <= EXC_VECTOR;
        state    <= DONE;
        busy     <= 1'b0;
        done     <= 1'b1;
        cnt      <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (req && aligned) begin
              mem_addr <= src;
              sel_err  <= src_err;
              if (WAIT_CYCLES == 0) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= WAIT;
                busy  <= 1'b1;
                cnt   <= CNT_INIT;
              end
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              misaligned <= req;
            end
          end
          WAIT: begin
            // Requests arriving here are dropped, not queued.
            if (cnt == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
